// File: rtl/amp_pwr_ctrl_if.sv
// Signal bundle between the power-stream source / gain consumer and amp_pwr_ctrl.
interface amp_pwr_ctrl_if #(
  parameter int GAIN_W = 8
);
  logic [15:0]       pwr_i;
  logic              pwr_valid_i;
  logic [15:0]       target_i;
  logic              enable_i;
  logic [GAIN_W-1:0] gain_o;
  logic              gain_valid_o;
  logic [15:0]       avg_o;
  logic              busy_o;

  modport master (
    output pwr_i, pwr_valid_i, target_i, enable_i,
    input  gain_o, gain_valid_o, avg_o, busy_o
  );

  modport slave (
    input  pwr_i, pwr_valid_i, target_i, enable_i,
    output gain_o, gain_valid_o, avg_o, busy_o
  );
endinterface

// File: rtl/amp_pwr_ctrl.sv
// Windowed-average AGC: steps a saturating gain by one LSB per 2^LOG2_N-sample window.
// Optional deadband around the target is built when AMP_PWR_HYST_EN is defined.
module amp_pwr_ctrl #(
  parameter int LOG2_N    = 4,
  parameter int GAIN_W    = 8,
  parameter int GAIN_INIT = 64,
  parameter int GAIN_MIN  = 1,
  parameter int GAIN_MAX  = 255,
  parameter int HYST      = 256
) (
  input  logic             clk,
  input  logic             rst,
  amp_pwr_ctrl_if.slave    bus
);
  localparam int ACC_W = 16 + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic [GAIN_W-1:0] G_INIT = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] G_MIN  = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] G_MAX  = GAIN_W'(GAIN_MAX);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, UPDATE} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;
  logic [15:0]       avg_p0;
  logic              dec_p0, inc_p0;
  logic              dec_p1, inc_p1;
  logic [15:0]       avg_p1;
  logic [GAIN_W-1:0] gain_p2;
  logic              vld_p2;

  function automatic logic [GAIN_W-1:0] gain_step(input logic [GAIN_W-1:0] g,
                                                   input logic dec, input logic inc);
    logic [GAIN_W-1:0] r;
    r = g;
    if (dec)      r = (g <= G_MIN) ? G_MIN : g - 1'b1;
    else if (inc) r = (g >= G_MAX) ? G_MAX : g + 1'b1;
    return r;
  endfunction

  assign avg_p0 = acc[ACC_W-1:LOG2_N];

`ifdef AMP_PWR_HYST_EN
  logic [16:0] hi_thr;
  logic [15:0] lo_thr;

  // Lower threshold floors at zero so a small target can never request more gain.
  always_comb begin
    hi_thr = {1'b0, bus.target_i} + 17'(HYST);
    lo_thr = (bus.target_i >= 16'(HYST)) ? bus.target_i - 16'(HYST) : 16'd0;
    dec_p0 = {1'b0, avg_p0} > hi_thr;
    inc_p0 = avg_p0 < lo_thr;
  end
`else
  localparam int unused_hyst = HYST;

  always_comb begin
    dec_p0 = avg_p0 > bus.target_i;
    inc_p0 = avg_p0 < bus.target_i;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable_i) state_nxt = ACCUM;
      ACCUM: begin
        if (!bus.enable_i)                              state_nxt = IDLE;
        else if (bus.pwr_valid_i && (cnt == CNT_LAST))  state_nxt = COMPARE;
      end
      COMPARE: state_nxt = UPDATE;
      UPDATE:  state_nxt = bus.enable_i ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      avg_p1  <= '0;
      dec_p1  <= 1'b0;
      inc_p1  <= 1'b0;
      gain_p2 <= G_INIT;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
        end
        // accumulate stage: samples only count while enabled in ACCUM
        ACCUM: begin
          if (bus.enable_i && bus.pwr_valid_i) begin
            acc <= acc + ACC_W'(bus.pwr_i);
            cnt <= cnt + 1'b1;
          end
        end
        // compare stage -> _p1
        COMPARE: begin
          avg_p1 <= avg_p0;
          dec_p1 <= dec_p0;
          inc_p1 <= inc_p0;
        end
        // update stage -> _p2
        UPDATE: begin
          gain_p2 <= gain_step(gain_p2, dec_p1, inc_p1);
          vld_p2  <= 1'b1;
          acc     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gain_o       = gain_p2;
  assign bus.gain_valid_o = vld_p2;
  assign bus.avg_o        = avg_p1;
  assign bus.busy_o       = (state != IDLE);
endmodule

// File: tb/tb_amp_pwr_ctrl.sv
// Scoreboard bench for amp_pwr_ctrl: window-level reference model feeds a queue, monitor pops on gain pulses.
module tb_amp_pwr_ctrl;
  localparam int LOG2_N    = 4;
  localparam int N         = 1 << LOG2_N;
  localparam int GAIN_W    = 8;
  localparam int GAIN_INIT = 64;
  localparam int GAIN_MIN  = 1;
  localparam int GAIN_MAX  = 255;
  localparam int HYST      = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  amp_pwr_ctrl_if #(.GAIN_W(GAIN_W)) bus();

  amp_pwr_ctrl #(
    .LOG2_N(LOG2_N), .GAIN_W(GAIN_W), .GAIN_INIT(GAIN_INIT),
    .GAIN_MIN(GAIN_MIN), .GAIN_MAX(GAIN_MAX), .HYST(HYST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gain;
    int avg;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulse  = 0;
  bit   mon_en   = 1'b0;
  int   last_gain;

  // Window-level reference: collect N accepted samples, two dead cycles, then one update.
  bit m_active;
  int m_sum, m_cnt, m_dead, m_avg, m_gain, m_tgt;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_sum    = 0;
    m_cnt    = 0;
    m_dead   = 0;
    m_avg    = 0;
    m_gain   = GAIN_INIT;
    m_tgt    = 0;
  endfunction

  function automatic void model_step(input bit en, input bit vld, input int p, input int tgt);
    bit up, dn;
    cyc++;
    if (!m_active) begin
      m_active = en;
      m_sum    = 0;
      m_cnt    = 0;
    end else if (m_dead == 2) begin
      m_avg  = m_sum / N;
      m_tgt  = tgt;
      m_dead = 1;
    end else if (m_dead == 1) begin
`ifdef AMP_PWR_HYST_EN
      dn = m_avg > m_tgt + HYST;
      up = m_avg < m_tgt - HYST;
`else
      dn = m_avg > m_tgt;
      up = m_avg < m_tgt;
`endif
      if (dn)      m_gain = (m_gain - 1 < GAIN_MIN) ? GAIN_MIN : m_gain - 1;
      else if (up) m_gain = (m_gain + 1 > GAIN_MAX) ? GAIN_MAX : m_gain + 1;
      sb_q.push_back('{gain: m_gain, avg: m_avg, cyc: cyc});
      m_sum    = 0;
      m_dead   = 0;
      m_active = en;
    end else if (!en) begin
      m_active = 1'b0;
      m_sum    = 0;
      m_cnt    = 0;
    end else if (vld) begin
      m_sum += p;
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt  = 0;
        m_dead = 2;
      end
    end
  endfunction

  task automatic step(input bit en, input bit vld, input int p, input int tgt);
    bus.enable_i    = en;
    bus.pwr_valid_i = vld;
    bus.pwr_i       = 16'(p);
    bus.target_i    = 16'(tgt);
    @(posedge clk);
    model_step(en, vld, p & 32'hFFFF, tgt & 32'hFFFF);
    #1;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic window(input int p, input int tgt);
    step(1'b1, 1'b0, 0, tgt);
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, p, tgt);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, tgt);
  endtask

  // Monitor: decoupled from stimulus, pops the scoreboard on each gain pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy", 32'(bus.busy_o), 32'(m_active));
      if (bus.gain_valid_o) begin
        n_pulse++;
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("gain", 32'(bus.gain_o), e.gain);
          check("avg", 32'(bus.avg_o), e.avg);
        end
      end else begin
        check("gain_hold", 32'(bus.gain_o), last_gain);
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          check("missing_pulse", cyc, sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
      end
      last_gain = 32'(bus.gain_o);
    end
  end

  initial begin
    int g0, p0, ramp, found;
    bus.enable_i    = 1'b0;
    bus.pwr_valid_i = 1'b0;
    bus.pwr_i       = '0;
    bus.target_i    = '0;
    model_reset();

    #2 rst = 1'b0;
    #10;
    check("rst_gain", 32'(bus.gain_o), GAIN_INIT);
    check("rst_avg", 32'(bus.avg_o), 0);
    check("rst_valid", 32'(bus.gain_valid_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    @(negedge clk);
    rst       = 1'b1;
    last_gain = GAIN_INIT;
    mon_en    = 1'b1;

    // single decrement window
    window(1000, 500);
    check("dec_gain", 32'(bus.gain_o), 63);
    check("dec_avg", 32'(bus.avg_o), 1000);

    // full-scale samples, equal target -> hold
    window(16'hFFFF, 16'hFFFF);
    check("max_avg", 32'(bus.avg_o), 32'hFFFF);
    check("hold_gain", 32'(bus.gain_o), 63);

    // upper saturation at full input rate
    for (int i = 0; i < 200 * (N + 2); i++) step(1'b1, 1'b1, 10, 5000);
    go_idle();
    check("sat_hi", 32'(bus.gain_o), GAIN_MAX);

    // deadband cases around target 1000
    window(1200, 1000);
`ifdef AMP_PWR_HYST_EN
    check("hyst_hold", 32'(bus.gain_o), 255);
`else
    check("hyst_hold", 32'(bus.gain_o), 254);
`endif
    window(1300, 1000);
`ifdef AMP_PWR_HYST_EN
    check("hyst_dec", 32'(bus.gain_o), 254);
`else
    check("hyst_dec", 32'(bus.gain_o), 253);
`endif

    // ramp input with continuous valid: samples in dead cycles must be dropped
    ramp = 0;
    for (int i = 0; i < 6 * (N + 2); i++) begin
      step(1'b1, 1'b1, ramp * 97, 30000);
      ramp++;
    end
    go_idle();

    // abort mid-window
    g0 = 32'(bus.gain_o);
    p0 = n_pulse;
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 5000, 0);
    step(1'b0, 1'b0, 0, 0);
    check("abort_busy", 32'(bus.busy_o), 0);
    go_idle();
    check("abort_gain", 32'(bus.gain_o), g0);
    check("abort_no_pulse", n_pulse, p0);
    window(5000, 0);
    check("reenable_one_update", n_pulse, p0 + 1);
    go_idle();

    // lower saturation
    for (int i = 0; i < 270 * (N + 2); i++) step(1'b1, 1'b1, 60000, 10);
    go_idle();
    check("sat_lo", 32'(bus.gain_o), GAIN_MIN);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 24) != 0, ($urandom % 4) != 0, int'($urandom % 65536),
           int'($urandom % 65536));
    go_idle();

    // asynchronous reset landing in UPDATE
    found = 0;
    step(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 200 && found == 0; i++) begin
      step(1'b1, 1'b1, int'($urandom % 65536), int'($urandom % 65536));
      if (m_dead == 1) found = 1;
    end
    check("reach_update", found, 1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_gain", 32'(bus.gain_o), GAIN_INIT);
    check("arst_avg", 32'(bus.avg_o), 0);
    check("arst_busy", 32'(bus.busy_o), 0);
    check("arst_valid", 32'(bus.gain_valid_o), 0);
    @(negedge clk);
    check("arst_no_pulse", 32'(bus.gain_valid_o), 0);
    rst = 1'b1;
    model_reset();
    sb_q.delete();
    last_gain = GAIN_INIT;
    mon_en    = 1'b1;
    window(100, 50);
    check("post_rst_gain", 32'(bus.gain_o), GAIN_INIT - 1);
    go_idle();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/amp_pwr_ctrl.md
# amp_pwr_ctrl

Automatic-gain controller for the amplitude-control path. Consumes the per-sample power stream produced by the squared-magnitude stage. Averages it over a fixed window of 2^LOG2_N valid samples, compares the average against a programmable target, and steps a saturating gain register up or down by one LSB per window. The gain word is fed back to the front-end scaler, closing the amplitude loop.

## Interface
- LOG2_N, 4, log2 of window length; window N = 2^LOG2_N valid samples; range 1..8
- GAIN_W, 8, gain register width
- GAIN_INIT, 64, gain value after reset
- GAIN_MIN, 1, lower saturation bound for gain
- GAIN_MAX, 255, upper saturation bound for gain
- HYST, 256, deadband half-width in power LSBs; used only with AMP_PWR_HYST_EN
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- pwr_i  input  16  power sample |z|^2; treated as unsigned
- pwr_valid_i  input  1  pwr_i valid this cycle
- target_i  input  16  unsigned target average power; sampled in COMPARE
- enable_i  input  1  loop enable, level-sensitive
- gain_o  output  GAIN_W  current gain, registered
- gain_valid_o  output  1  one-cycle pulse on every gain update, including hold and saturated decisions
- avg_o  output  16  last window average, registered
- busy_o  output  1  high whenever state != IDLE

## Operation
- Reset values (rst low, asynchronous):
  - state = IDLE, acc = 0, cnt = 0
  - gain_o = GAIN_INIT, avg_o = 0, gain_valid_o = 0, busy_o = 0
- State machine, four states:
  - IDLE: acc and cnt cleared. enable_i=1 moves to ACCUM.
  - ACCUM: each cycle with pwr_valid_i=1, acc += pwr_i and cnt += 1.
    - acc is 16+LOG2_N bits wide and never overflows.
    - On the valid sample with cnt == N-1, the next state is COMPARE; cnt wraps to 0.
  - COMPARE: avg = acc >> LOG2_N (truncating), registered into avg_o. The direction decision is registered. Next state is UPDATE.
  - UPDATE: gain_o changes by -1, +1 or 0, saturating at GAIN_MIN and GAIN_MAX. gain_valid_o pulses. acc is cleared.
    - Next state is ACCUM if enable_i=1, else IDLE.
- Direction rule, without the macro:
  - avg > target_i: decrement
  - avg < target_i: increment
  - avg == target_i: hold
- pwr_valid_i in COMPARE or UPDATE: the sample is dropped. It is not counted toward the next window.
- enable_i falls during ACCUM: abort to IDLE on the next edge. The partial window is discarded; gain_o and avg_o are held.
- enable_i falls during COMPARE or UPDATE: the current update completes, then the block goes to IDLE.
- pwr_valid_i and the transition into ACCUM from IDLE in the same cycle: the sample is not counted. Counting starts in the first ACCUM cycle.
- gain_o stays constant between updates. Downstream logic may sample it at any time.

## Timing
- Let cycle t carry the Nth valid sample.
  - Cycle t+1: COMPARE.
  - Cycle t+2: UPDATE. avg_o shows the new average in this cycle.
  - Cycle t+3: gain_o shows the new value and gain_valid_o=1. The state is back in ACCUM.
- Latency from last window sample to the gain update is 3 cycles.
- Samples arriving in cycles t+1 and t+2 are dropped.
- Minimum window period is N+2 cycles at a full-rate input.
- busy_o drops in the first IDLE cycle.
- A reset mid-window returns every register to its reset value immediately. No gain_valid_o pulse is produced.

## Configuration
- AMP_PWR_HYST_EN defined: deadband around the target.
  - Decrement only if avg > target_i + HYST. The sum is computed in 17 bits.
  - Increment only if avg < target_i - HYST. The difference saturates at 0, so no increment is possible when target_i < HYST.
  - Otherwise hold.
- AMP_PWR_HYST_EN undefined: the plain comparison in Operation applies. HYST is unused and no deadband logic is built.

## Test plan
- Window with decrement: reset, enable_i=1, 16 samples pwr_i=1000, target_i=500 -> avg_o=1000 at t+2; gain_o=63 with gain_valid_o pulse at t+3.
- Boundary values: 16 samples pwr_i=0xFFFF -> avg_o=0xFFFF with no overflow.
  - Then with target_i=0xFFFF -> hold at gain 63 and still a gain_valid_o pulse.
- Upper saturation: gain forced to 255 via repeated windows of pwr_i=10, target_i=5000.
  - -> 191 consecutive increments from 64, then gain_o stays 255 while gain_valid_o keeps pulsing every window.
- Abort mid-window: 9 valid samples, then enable_i=0 -> IDLE next edge, busy_o=0, no pulse, gain_o unchanged.
  - Re-enable then 16 samples -> exactly one update.
- Dropped samples: pwr_valid_i held high continuously -> updates every 18 cycles.
  - Samples in COMPARE/UPDATE are excluded from avg_o; use a ramp input to check.
- Reset and hysteresis:
  - Asynchronous rst pulse during UPDATE -> gain_o=64, avg_o=0 immediately.
  - With AMP_PWR_HYST_EN: target_i=1000, avg=1200 -> hold; avg=1300 -> decrement.
